// File: rtl/noc_outport_arbiter.sv
// Output-port arbiter: round-robin grant over five input queues, pops one flit,
// waits a bounded time for its data, and holds it on data_o until accepted.
module noc_outport_arbiter #(
   parameter int unsigned TIMEOUT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  req_i,
   input  logic [4:0]  en_i,
   input  logic [15:0] data0_i,
   input  logic [15:0] data1_i,
   input  logic [15:0] data2_i,
   input  logic [15:0] data3_i,
   input  logic [15:0] data4_i,
   input  logic        ready_i,
   output logic [4:0]  pop_req_o,
   output logic [15:0] data_o,
   output logic        valid_o,
   output logic [2:0]  grant_o,
   output logic        err_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] POP  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [2:0]  grant_q, grant_d;
   logic [4:0]  pop_q, pop_d;
   logic [15:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [2:0]  cnt_q, cnt_d;

   logic [2:0]  winner;
   logic        found;
   logic [3:0]  sum;
   logic        sel_en;
   logic [15:0] sel_data;
   logic [2:0]  next_ptr;

   // First requester at or after ptr, wrapping 4 -> 0.
   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      sum    = '0;
      for (int i = 0; i < 5; i++) begin
         sum = {1'b0, ptr_q} + 4'(i);
         if (sum > 4'd4) sum = sum - 4'd5;
         if (!found && req_i[sum[2:0]]) begin
            winner = sum[2:0];
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_en   = 1'b0;
      sel_data = '0;
      case (grant_q)
         3'd0:    begin sel_en = en_i[0]; sel_data = data0_i; end
         3'd1:    begin sel_en = en_i[1]; sel_data = data1_i; end
         3'd2:    begin sel_en = en_i[2]; sel_data = data2_i; end
         3'd3:    begin sel_en = en_i[3]; sel_data = data3_i; end
         3'd4:    begin sel_en = en_i[4]; sel_data = data4_i; end
         default: begin sel_en = 1'b0;    sel_data = '0;      end
      endcase
   end

   assign next_ptr = (grant_q == 3'd4) ? 3'd0 : grant_q + 3'd1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      pop_d   = '0;
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               grant_d = winner;
               pop_d   = 5'b00001 << winner;
               state_d = POP;
            end
         end
         POP: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (sel_en) begin
               data_d  = sel_data;
               valid_d = 1'b1;
               ptr_d   = next_ptr;
               cnt_d   = '0;
               state_d = HOLD;
            end else if (cnt_q >= 3'(TIMEOUT - 1)) begin
               // This cycle is the last allowed WAIT cycle.
               err_d   = 1'b1;
               ptr_d   = next_ptr;
               cnt_d   = 3'(TIMEOUT);
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         HOLD: begin
            if (ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         pop_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         pop_q   <= pop_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pop_req_o = pop_q;
   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign grant_o   = grant_q;
   assign err_o     = err_q;

endmodule
